johnson_decoder: RTL and testbench



---
 rtl/johnson_decoder_pkg.sv | 10 +
 rtl/johnson_code_decode.sv | 26 ++
 rtl/johnson_decoder.sv | 102 ++++++++++
 tb/tb_johnson_decoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/johnson_decoder_pkg.sv
// johnson_decoder_pkg: shared FSM state type and phase-width helper for the Johnson decoder.
package johnson_decoder_pkg;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    function automatic int phase_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// johnson_code_decode: combinational Johnson code word to {legal, phase} lookup.
module johnson_code_decode
    import johnson_decoder_pkg::*;
#(
    parameter int N = 3,
    localparam int PW = phase_w(N)
) (
    input  logic [N-1:0]  i_code,
    output logic          o_legal,
    output logic [PW-1:0] o_phase
);

    localparam logic [N-1:0] ONES = '1;

    // phases 0..N fill ones from the MSB down, phases N+1..2N-1 drain them from the MSB
    always_comb begin
        o_legal = 1'b0;
        o_phase = '0;
        for (int p = 0; p < 2 * N; p++)
            if (i_code == ((p <= N) ? ~(ONES >> p) : (ONES >> (p - N)))) begin
                o_legal = 1'b1;
                o_phase = PW'(p);
            end
    end

endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: samples a Johnson code word, decodes phase and one-hot,
// flags illegal codes and sequence errors, and tracks lock to the ring.
module johnson_decoder
    import johnson_decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int LOCK_CNT   = 4,
    parameter bit ALLOW_HOLD = 1'b0,
    parameter int CNT_W      = 8,
    localparam int PW        = phase_w(N),
    localparam int P2        = 2 * N
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [N-1:0]     i_code,
    input  logic             i_clr_err,
    output logic             o_valid,
    output logic [PW-1:0]    o_phase,
    output logic [P2-1:0]    o_onehot,
    output logic             o_illegal_code,
    output logic             o_seq_err,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_err_cnt
);

    state_t        state;
    logic          dec_legal;
    logic [PW-1:0] dec_phase;
    logic [PW-1:0] prev_phase;
    logic          prev_valid;
    logic [3:0]    run;
    logic [PW-1:0] succ;
    logic          match;
    logic          seq_err;
    logic          err_evt;
    logic [3:0]    run_nxt;

    johnson_code_decode #(.N(N)) u_dec (
        .i_code  (i_code),
        .o_legal (dec_legal),
        .o_phase (dec_phase)
    );

    always_comb begin
        succ    = (prev_phase == PW'(P2 - 1)) ? '0 : prev_phase + PW'(1);
        match   = prev_valid && (dec_phase == succ || (ALLOW_HOLD && dec_phase == prev_phase));
        seq_err = i_en && dec_legal && state == LOCKED && !match;
        err_evt = (i_en && !dec_legal) || seq_err;
        run_nxt = match ? run + 4'd1 : 4'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= UNLOCKED;
            prev_phase     <= '0;
            prev_valid     <= 1'b0;
            run            <= '0;
            o_valid        <= 1'b0;
            o_phase        <= '0;
            o_onehot       <= '0;
            o_illegal_code <= 1'b0;
            o_seq_err      <= 1'b0;
            o_locked       <= 1'b0;
            o_err_cnt      <= '0;
        end else begin
            o_valid        <= i_en;
            o_illegal_code <= i_en && !dec_legal;
            o_seq_err      <= seq_err;
            if (i_clr_err)
                o_err_cnt <= '0;
            else if (err_evt && o_err_cnt != '1)
                o_err_cnt <= o_err_cnt + CNT_W'(1);
            if (i_en && !dec_legal) begin
                o_onehot   <= '0;
                prev_valid <= 1'b0;
                run        <= '0;
                state      <= UNLOCKED;
                o_locked   <= 1'b0;
            end else if (i_en) begin
                o_phase    <= dec_phase;
                o_onehot   <= {{(P2 - 1){1'b0}}, 1'b1} << dec_phase;
                prev_phase <= dec_phase;
                prev_valid <= 1'b1;
                if (state == LOCKED) begin
                    if (!match) begin
                        run      <= 4'd1;
                        state    <= UNLOCKED;
                        o_locked <= 1'b0;
                    end
                end else begin
                    run <= run_nxt;
                    if (run_nxt == 4'(LOCK_CNT)) begin
                        state    <= LOCKED;
                        o_locked <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: three decoders (strict, hold-allowed, 2-bit counter) against a ring model.
module tb_johnson_decoder;

    localparam int N    = 3;
    localparam int P2   = 6;
    localparam int LOCK = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       clr   = 1'b0;
    logic [2:0] code  = '0;

    always #5 clk = ~clk;

    wire [2:0] o_v, o_ill, o_seq, o_lk;
    wire [2:0] o_ph [3];
    wire [5:0] o_oh [3];
    wire [7:0] o_cnt [3];
    wire [1:0] cnt_s;

    assign o_cnt[2] = {6'b0, cnt_s};

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK), .ALLOW_HOLD(1'b0), .CNT_W(8)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_code(code), .i_clr_err(clr),
        .o_valid(o_v[0]), .o_phase(o_ph[0]), .o_onehot(o_oh[0]), .o_illegal_code(o_ill[0]),
        .o_seq_err(o_seq[0]), .o_locked(o_lk[0]), .o_err_cnt(o_cnt[0])
    );

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK), .ALLOW_HOLD(1'b1), .CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_code(code), .i_clr_err(clr),
        .o_valid(o_v[1]), .o_phase(o_ph[1]), .o_onehot(o_oh[1]), .o_illegal_code(o_ill[1]),
        .o_seq_err(o_seq[1]), .o_locked(o_lk[1]), .o_err_cnt(o_cnt[1])
    );

    johnson_decoder #(.N(N), .LOCK_CNT(LOCK), .ALLOW_HOLD(1'b0), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_code(code), .i_clr_err(clr),
        .o_valid(o_v[2]), .o_phase(o_ph[2]), .o_onehot(o_oh[2]), .o_illegal_code(o_ill[2]),
        .o_seq_err(o_seq[2]), .o_locked(o_lk[2]), .o_err_cnt(cnt_s)
    );

    int m_prev[3], m_pv[3], m_run[3], m_lk[3], m_cnt[3];
    int m_ph[3], m_oh[3], m_v[3], m_ill[3], m_seq[3];
    int hold[3] = '{0, 1, 0};
    int cmax[3] = '{255, 255, 3};
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ring position p as a code word: p ones entering from the top, then leaving from the top
    function automatic int enc(input int p);
        return (p <= N) ? (((1 << p) - 1) << (N - p)) : ((1 << (P2 - p)) - 1);
    endfunction

    function automatic void ref_dec(input int c, output int legal, output int ph);
        int ones = 0;
        for (int b = 0; b < N; b++) ones += (c >> b) & 1;
        legal = 1;
        if (c == (((1 << ones) - 1) << (N - ones))) ph = ones;
        else if (c == ((1 << ones) - 1)) ph = P2 - ones;
        else begin legal = 0; ph = 0; end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = 0; m_pv[i] = 0; m_run[i] = 0; m_lk[i] = 0; m_cnt[i] = 0;
            m_ph[i] = 0; m_oh[i] = 0; m_v[i] = 0; m_ill[i] = 0; m_seq[i] = 0;
        end
    endtask

    task automatic model_step(input int e, input int c, input int cl);
        int legal, ph, ok;
        ref_dec(c, legal, ph);
        for (int i = 0; i < 3; i++) begin
            ok = m_pv[i] && (ph == (m_prev[i] + 1) % P2 || (hold[i] && ph == m_prev[i]));
            m_v[i]   = e;
            m_ill[i] = e && !legal;
            m_seq[i] = e && legal && m_lk[i] && !ok;
            if (cl) m_cnt[i] = 0;
            else if ((m_ill[i] || m_seq[i]) && m_cnt[i] < cmax[i]) m_cnt[i]++;
            if (e && !legal) begin
                m_oh[i] = 0; m_pv[i] = 0; m_run[i] = 0; m_lk[i] = 0;
            end else if (e) begin
                m_ph[i] = ph;
                m_oh[i] = 1 << ph;
                if (m_lk[i]) begin
                    if (!ok) begin m_run[i] = 1; m_lk[i] = 0; end
                end else begin
                    m_run[i] = ok ? m_run[i] + 1 : 1;
                    if (m_run[i] >= LOCK) m_lk[i] = 1;
                end
                m_prev[i] = ph;
                m_pv[i] = 1;
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid%0d", i),   {31'b0, o_v[i]},   m_v[i]);
            chk($sformatf("phase%0d", i),   {29'b0, o_ph[i]},  m_ph[i]);
            chk($sformatf("onehot%0d", i),  {26'b0, o_oh[i]},  m_oh[i]);
            chk($sformatf("illegal%0d", i), {31'b0, o_ill[i]}, m_ill[i]);
            chk($sformatf("seqerr%0d", i),  {31'b0, o_seq[i]}, m_seq[i]);
            chk($sformatf("locked%0d", i),  {31'b0, o_lk[i]},  m_lk[i]);
            chk($sformatf("errcnt%0d", i),  {24'b0, o_cnt[i]}, m_cnt[i]);
        end
    endtask

    task automatic cyc(input int e, input int c, input int cl);
        en   = e[0];
        code = c[2:0];
        clr  = cl[0];
        @(posedge clk);
        model_step(e, c, cl);
        #1 compare();
    endtask

    int dir[$] = '{0, 4, 6, 7, 3, 1, 0, 4, 2, 0, 4, 6, 7, 3, 1, 0, 4, 6, 3, 1, 0, 4, 6, 7, 7};

    initial begin
        int r, c;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare();
        rst_n = 1'b1;
        foreach (dir[k]) begin
            cyc(1, dir[k], 0);
            if (k == 3) chk("lock_on_4th", {31'b0, o_lk[0]}, 1);
            if (k == 8) chk("illegal_hold_phase", {29'b0, o_ph[0]}, 1);
        end
        chk("hold_keeps_lock", {31'b0, o_lk[1]}, 1);
        cyc(0, 2, 0);
        cyc(0, 5, 0);
        cyc(1, 2, 0);
        cyc(1, 5, 0);
        cyc(1, 2, 0);
        cyc(1, 5, 0);
        chk("sat_cnt2", {24'b0, o_cnt[2]}, 3);
        cyc(1, 2, 1);
        chk("clr_wins", {24'b0, o_cnt[2]}, 0);
        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 9);
            c = (r < 6) ? enc((m_prev[0] + 1) % P2) : (r < 8) ? enc(m_prev[0]) : $urandom_range(0, 7);
            cyc(($urandom_range(0, 3) != 0) ? 1 : 0, c, ($urandom_range(0, 31) == 0) ? 1 : 0);
        end
        en  = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        model_step(0, 0, 0);
        #3 rst_n = 1'b0;
        model_reset();
        #1 compare();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) cyc(1, enc(k), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
